control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port clr_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port instr, input, 32 bits: instruction word from instruction memory.
REQ-004 The block SHALL have port instr_valid, input, 1 bit: instr is valid this cycle.
REQ-005 The block SHALL have port instr_ready, output, 1 bit: sequencer accepts instr this cycle.
REQ-006 The block SHALL have port pc_in, input, 32 bits: current program counter value.
REQ-007 The block SHALL have ports f_zero and f_overflow, inputs, 1 bit each: ALU flags.
REQ-008 The block SHALL have port write, output, 1 bit: register file write strobe.
REQ-009 The block SHALL have ports inc and ld, outputs, 1 bit each: PC increment and PC load strobes.
REQ-010 The block SHALL have ports read_reg_1, read_reg_2 and write_reg, outputs, 5 bits each: register file addresses.
REQ-011 The block SHALL have port alu_op, output, 32 bits: ALU operation; bits [31:2] are always 0.
REQ-012 The block SHALL have port imm, output, 32 bits: sign-extended immediate.
REQ-013 The block SHALL have port sel_imm, output, 1 bit: ALU B operand selects imm.
REQ-014 The block SHALL have port pc_target, output, 32 bits: PC load value, valid whenever ld=1.
REQ-015 The block SHALL have port trap, output, 1 bit: overflow trap latched.

Function
REQ-016 The state machine SHALL have states FETCH, DECODE, EXEC, WB and TRAP.
REQ-017 In FETCH: instr_ready=1; the instruction word SHALL be latched when instr_valid && instr_ready, then go to DECODE.
REQ-018 In FETCH with instr_valid=0, the block SHALL stay in FETCH and assert no strobe.
REQ-019 In DECODE: read_reg_1=rs, read_reg_2=rt, alu_op and sel_imm and imm driven from the latched word; next state EXEC.
REQ-020 Addresses, alu_op, sel_imm and imm SHALL hold stable from DECODE through the end of WB.
REQ-021 alu_op encoding SHALL be: 00 add, 01 sub, 10 and, 11 or.
REQ-022 R-type SHALL decode as: opcode 0x00; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
REQ-023 Other I/J opcodes SHALL decode as: addi 0x08 (add, sel_imm=1); beq 0x04 (sub); j 0x02.
REQ-024 EXEC for R-type/addi SHALL go to WB.
REQ-025 EXEC for beq SHALL sample f_zero: if 1, ld=1 and pc_target = pc_in + 4 + (sext(imm16) << 2); if 0, inc=1; next state FETCH.
REQ-026 EXEC for j SHALL assert ld=1 with pc_target = {pc_in[31:28], instr[25:0], 2'b00}; next state FETCH.
REQ-027 In WB: write=1 and inc=1 for one cycle; write_reg=rd for R-type, rt for addi; next state FETCH.
REQ-028 A destination of register 0 SHALL force write=0 in WB; inc is still asserted.
REQ-029 An unknown opcode or funct SHALL be executed as a NOP: inc=1 in EXEC, then FETCH.
REQ-030 Latency SHALL be: handshake to WB strobes = 3 cycles; R-type/addi occupies 4 cycles, beq/j/NOP 3 cycles.
REQ-031 write, inc and ld SHALL be single-cycle pulses and mutually exclusive except write+inc in WB.
REQ-032 All arithmetic SHALL be 32-bit modulo; the pc_target add wraps silently.

Reset
REQ-033 While clr_n=0, the block SHALL be in state FETCH with instr_ready=0.
REQ-034 While clr_n=0, the block SHALL drive write=inc=ld=trap=0, all addresses 0, alu_op=0, imm=0, sel_imm=0, pc_target=0 and the latched instr=0.
REQ-035 instr_ready SHALL rise in the first cycle after clr_n deasserts.
REQ-036 Reset in any state, including mid-EXEC/WB and TRAP, SHALL abort the instruction with no strobe emitted.

Configuration
REQ-037 With OVERFLOW_TRAP_EN defined: f_overflow=1 sampled in EXEC for add/sub/addi SHALL go to TRAP with no write and no inc.
REQ-038 With OVERFLOW_TRAP_EN defined, TRAP SHALL hold trap=1, instr_ready=0 and all strobes 0 until clr_n.
REQ-039 Without OVERFLOW_TRAP_EN: f_overflow SHALL be ignored, the TRAP state SHALL be absent, and trap SHALL be tied to 0.

Structure
REQ-040 Package cs_pkg SHALL hold the state enum, the alu_op enum, and the opcode/funct constants.
REQ-041 A combinational sub-module instr_decoder SHALL map the instruction word to a decoded-control struct (in cs_pkg); the sequencer registers it.

Verification
REQ-042 Reset: clr_n=0 mid-WB -> write=0 immediately; instr_ready=1 in the first cycle after release.
REQ-043 add: instr 0x00221820 -> DECODE read_reg_1=1, read_reg_2=2, alu_op=00; WB write=1, write_reg=3, inc=1.
REQ-044 beq: instr 0x10220004, pc_in=0x100, f_zero=1 -> ld=1, pc_target=0x114; same with f_zero=0 -> inc=1, ld=0.
REQ-045 j: instr 0x08000040, pc_in=0x10000000 -> ld=1, pc_target=0x10000100.
REQ-046 addi: instr 0x2000FFFF (rt=0) -> imm=0xFFFFFFFF, sel_imm=1, WB write=0, inc=1.
REQ-047 Overflow: add with f_overflow=1 -> with OVERFLOW_TRAP_EN, trap=1 and no write/inc; without it, normal WB.
REQ-048 Stall: instr_valid=0 for 10 cycles -> stays in FETCH with no strobes.

Source files
------------

// File: rtl/cs_pkg.sv
// cs_pkg: shared types and constants for control_sequencer.
//   - state_t    : sequencer state encoding (TRAP exists only with OVERFLOW_TRAP_EN)
//   - alu_op_t   : 2-bit ALU operation code (00 add, 01 sub, 10 and, 11 or)
//   - kind_t     : instruction class produced by the decoder
//   - dec_t      : decoded-control struct registered by the sequencer
//   - opcode/funct constants and a 16->32 sign-extension helper
package cs_pkg;

`ifdef OVERFLOW_TRAP_EN
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_TRAP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3
  } state_t;
`endif

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  // K_ALU writes back through WB; K_NOP covers every unknown opcode/funct.
  typedef enum logic [1:0] {
    K_NOP = 2'd0,
    K_ALU = 2'd1,
    K_BEQ = 2'd2,
    K_J   = 2'd3
  } kind_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;       // destination; 0 means no register write
    alu_op_t     alu_op;
    logic        sel_imm;
    logic [31:0] imm;
    kind_t       kind;
    logic        ovf_chk;  // add/sub/addi: an overflow flag is meaningful
  } dec_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/control_sequencer_decoder.sv
// instr_decoder: purely combinational map from a 32-bit instruction word to
// the dec_t control struct.
// Ports:
//   i_instr : instruction word
//   o_dec   : decoded control (addresses, alu op, immediate, class)
module instr_decoder
  import cs_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  always_comb begin
    o_dec         = '0;
    o_dec.rs      = i_instr[25:21];
    o_dec.rt      = i_instr[20:16];
    o_dec.imm     = sext16(i_instr[15:0]);
    o_dec.alu_op  = ALU_ADD;
    o_dec.kind    = K_NOP;
    o_dec.sel_imm = 1'b0;
    o_dec.wr      = 5'd0;
    o_dec.ovf_chk = 1'b0;
    case (i_instr[31:26])
      OP_RTYPE: begin
        case (i_instr[5:0])
          FN_ADD: begin
            o_dec.kind    = K_ALU;
            o_dec.alu_op  = ALU_ADD;
            o_dec.wr      = i_instr[15:11];
            o_dec.ovf_chk = 1'b1;
          end
          FN_SUB: begin
            o_dec.kind    = K_ALU;
            o_dec.alu_op  = ALU_SUB;
            o_dec.wr      = i_instr[15:11];
            o_dec.ovf_chk = 1'b1;
          end
          FN_AND: begin
            o_dec.kind   = K_ALU;
            o_dec.alu_op = ALU_AND;
            o_dec.wr     = i_instr[15:11];
          end
          FN_OR: begin
            o_dec.kind   = K_ALU;
            o_dec.alu_op = ALU_OR;
            o_dec.wr     = i_instr[15:11];
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        o_dec.kind    = K_ALU;
        o_dec.alu_op  = ALU_ADD;
        o_dec.sel_imm = 1'b1;
        o_dec.wr      = i_instr[20:16];
        o_dec.ovf_chk = 1'b1;
      end
      OP_BEQ: begin
        o_dec.kind   = K_BEQ;
        o_dec.alu_op = ALU_SUB;
      end
      OP_J: begin
        o_dec.kind = K_J;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXEC/WB control FSM for a small
// MIPS-like datapath.
// Build option: define OVERFLOW_TRAP_EN to enable the sticky overflow TRAP
// state; without it f_overflow is ignored and trap is tied low.
// Ports:
//   clk, clr_n              : clock, asynchronous active-low reset
//   instr, instr_valid      : instruction word and its valid
//   instr_ready             : sequencer can take an instruction (FETCH only)
//   pc_in                   : current PC, used for branch/jump targets
//   f_zero, f_overflow      : ALU flags sampled in EXEC
//   write, inc, ld          : register-write, PC-increment, PC-load strobes
//   read_reg_1/2, write_reg : register file addresses
//   alu_op, imm, sel_imm    : ALU controls
//   pc_target               : PC load value (non-zero only while ld=1)
//   trap                    : overflow trap latched
//   dbg_state               : current FSM state
//
// Handshake: an instruction is accepted on a rising edge where
// instr_valid && instr_ready are both 1; instr_ready is registered and is 1
// only while the FSM sits in FETCH out of reset. The producer must hold instr
// stable while instr_valid is 1 and not yet accepted.
module control_sequencer
  import cs_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] pc_in,
  input  logic        f_zero,
  input  logic        f_overflow,
  output logic        write,
  output logic        inc,
  output logic        ld,
  output logic [4:0]  read_reg_1,
  output logic [4:0]  read_reg_2,
  output logic [4:0]  write_reg,
  output logic [31:0] alu_op,
  output logic [31:0] imm,
  output logic        sel_imm,
  output logic [31:0] pc_target,
  output logic        trap,
  output logic [2:0]  dbg_state
);

  state_t      r_state;
  logic [31:0] r_instr;
  dec_t        r_dec;
  logic        r_instr_ready;
  dec_t        w_dec;
  logic        w_in_exec;
  logic [31:0] w_target;

  // Decode the incoming word so the registered result is already on the
  // outputs during DECODE.
  instr_decoder u_dec (
    .i_instr (instr),
    .o_dec   (w_dec)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state       <= S_FETCH;
      r_instr       <= '0;
      r_dec         <= '0;
      r_instr_ready <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_instr_ready <= 1'b1;
          if (instr_valid && r_instr_ready) begin
            r_instr       <= instr;
            r_dec         <= w_dec;
            r_state       <= S_DECODE;
            r_instr_ready <= 1'b0;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
`ifdef OVERFLOW_TRAP_EN
          if (r_dec.ovf_chk && f_overflow) begin
            r_state <= S_TRAP;
          end else
`endif
          if (r_dec.kind == K_ALU) begin
            r_state <= S_WB;
          end else begin
            r_state       <= S_FETCH;
            r_instr_ready <= 1'b1;
          end
        end
        S_WB: begin
          r_state       <= S_FETCH;
          r_instr_ready <= 1'b1;
        end
`ifdef OVERFLOW_TRAP_EN
        S_TRAP: begin
          r_state       <= S_TRAP;
          r_instr_ready <= 1'b0;
        end
`endif
        default: begin
          r_state       <= S_FETCH;
          r_instr_ready <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are decoded from the registered state; EXEC strobes also depend
  // on f_zero, which is only meaningful during EXEC.
  assign w_in_exec = (r_state == S_EXEC);

  always_comb begin
    w_target = 32'd0;
    if (r_dec.kind == K_J) begin
      w_target = {pc_in[31:28], r_instr[25:0], 2'b00};
    end else begin
      w_target = pc_in + 32'd4 + {r_dec.imm[29:0], 2'b00};
    end
  end

  assign ld    = w_in_exec && ((r_dec.kind == K_J) || ((r_dec.kind == K_BEQ) && f_zero));
  assign inc   = (r_state == S_WB) ||
                 (w_in_exec && ((r_dec.kind == K_NOP) || ((r_dec.kind == K_BEQ) && !f_zero)));
  assign write = (r_state == S_WB) && (r_dec.wr != 5'd0);

  assign pc_target   = ld ? w_target : 32'd0;
  assign instr_ready = r_instr_ready;
  assign read_reg_1  = r_dec.rs;
  assign read_reg_2  = r_dec.rt;
  assign write_reg   = r_dec.wr;
  assign alu_op      = {30'd0, r_dec.alu_op};
  assign imm         = r_dec.imm;
  assign sel_imm     = r_dec.sel_imm;
  assign dbg_state   = r_state;

`ifdef OVERFLOW_TRAP_EN
  assign trap = (r_state == S_TRAP);
  logic [5:0] w_unused;
  assign w_unused = r_instr[31:26];
`else
  assign trap = 1'b0;
  logic [7:0] w_unused;
  assign w_unused = {r_instr[31:26], f_overflow, r_dec.ovf_chk};
`endif

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int W = 132;

  logic        clk;
  logic        clr_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_in;
  logic        f_zero;
  logic        f_overflow;
  logic        write;
  logic        inc;
  logic        ld;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [4:0]  write_reg;
  logic [31:0] alu_op;
  logic [31:0] imm;
  logic        sel_imm;
  logic [31:0] pc_target;
  logic        trap;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];

  control_sequencer dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_in       (pc_in),
    .f_zero      (f_zero),
    .f_overflow  (f_overflow),
    .write       (write),
    .inc         (inc),
    .ld          (ld),
    .read_reg_1  (read_reg_1),
    .read_reg_2  (read_reg_2),
    .write_reg   (write_reg),
    .alu_op      (alu_op),
    .imm         (imm),
    .sel_imm     (sel_imm),
    .pc_target   (pc_target),
    .trap        (trap),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pk(
    input logic [15:0] c, input logic wr, input logic in, input logic l, input logic tr,
    input logic [4:0] wreg, input logic [4:0] rr1, input logic [4:0] rr2,
    input logic [31:0] alu, input logic sel, input logic [31:0] im, input logic [31:0] pct);
    return {c, wr, in, l, tr, wreg, rr1, rr2, alu, sel, im, pct};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one instruction. lat = cycles from handshake to the strobe event
  // (0: no strobe expected). loose[0] ignores alu_op[1:0]/sel_imm,
  // loose[1] ignores write_reg.
  task automatic issue(input string nm, input logic [31:0] iw, input logic [31:0] pc,
                       input logic fz, input logic fov, input int lat,
                       input logic wr, input logic in, input logic l,
                       input logic [4:0] wreg, input logic [4:0] rr1, input logic [4:0] rr2,
                       input logic [1:0] alu, input logic sel,
                       input logic [31:0] im, input logic [31:0] pct,
                       input logic [1:0] loose);
    int n;
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!instr_ready) begin
      failures++;
      $display("FAIL %s_handshake: instr_ready=0 after %0d cycles, required 1", nm, n);
      return;
    end
    pc_in = pc;
    f_zero = fz;
    f_overflow = fov;
    instr = iw;
    instr_valid = 1'b1;
    if (lat > 0) begin
      exp_q.push_back(pk(16'(cyc + lat), wr, in, l, 1'b0, wreg, rr1, rr2,
                         {30'd0, alu}, sel, im, pct));
      mask_q.push_back(pk(16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1,
                          loose[1] ? 5'h00 : 5'h1F, 5'h1F, 5'h1F,
                          {30'h3FFFFFFF, loose[0] ? 2'b00 : 2'b11}, ~loose[0],
                          32'hFFFFFFFF, 32'hFFFFFFFF));
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 32'hDEADBEEF;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk({nm, "_trap"}, {31'd0, trap}, 32'd0);
    chk({nm, "_strobes"}, {29'd0, write, inc, ld}, 32'd0);
    chk({nm, "_state"}, {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    chk({nm, "_ready_after_release"}, {31'd0, instr_ready}, 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (clr_n === 1'b1 && (write || inc || ld)) begin
      logic [W-1:0] obs, e, m;
      string nm;
      obs = pk(cyc[15:0], write, inc, ld, trap, write_reg, read_reg_1, read_reg_2,
               alu_op, sel_imm, imm, pc_target);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got event 0x%033h, required no strobe", obs);
      end else begin
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        nm = name_q.pop_front();
        if ((obs & m) !== (e & m)) begin
          failures++;
          $display("FAIL %s: got {cyc,w,i,l,t,wreg,rr1,rr2,alu,sel,imm,pct}=0x%033h, required 0x%033h (care 0x%033h)",
                   nm, obs & m, e & m, m);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    clr_n = 1'b1;
    instr = 32'd0;
    instr_valid = 1'b0;
    pc_in = 32'd0;
    f_zero = 1'b0;
    f_overflow = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    chk("rst_write",     {31'd0, write}, 32'd0);
    chk("rst_inc",       {31'd0, inc}, 32'd0);
    chk("rst_ld",        {31'd0, ld}, 32'd0);
    chk("rst_trap",      {31'd0, trap}, 32'd0);
    chk("rst_ready",     {31'd0, instr_ready}, 32'd0);
    chk("rst_addrs",     {17'd0, read_reg_1, read_reg_2, write_reg}, 32'd0);
    chk("rst_alu_op",    alu_op, 32'd0);
    chk("rst_imm",       imm, 32'd0);
    chk("rst_sel_imm",   {31'd0, sel_imm}, 32'd0);
    chk("rst_pc_target", pc_target, 32'd0);
    chk("rst_state",     {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    chk("ready_at_release", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("ready_first_cycle", {31'd0, instr_ready}, 32'd1);

    // Stall: no valid for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_state_strobes", {26'd0, dbg_state, write, inc, ld}, {26'd0, 3'd0, 3'b000});
    end

    //     name        instr         pc_in         fz    fov  lat wr   inc  ld   wreg  rr1    rr2    alu    sel   imm           pc_target     loose
    issue("add",       32'h00221820, 32'h0,        1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 5'd3,  5'd1,  5'd2,  2'b00, 1'b0, 32'h00001820, 32'h0,        2'b00);
    issue("sub",       32'h00A43022, 32'h0,        1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 5'd6,  5'd5,  5'd4,  2'b01, 1'b0, 32'h00003022, 32'h0,        2'b00);
    issue("and",       32'h00E84824, 32'h0,        1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 5'd9,  5'd7,  5'd8,  2'b10, 1'b0, 32'h00004824, 32'h0,        2'b00);
    issue("or",        32'h0021F825, 32'h0,        1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 5'd31, 5'd1,  5'd1,  2'b11, 1'b0, 32'hFFFFF825, 32'h0,        2'b00);
    issue("add_rd0",   32'h00220020, 32'h0,        1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  2'b00, 1'b0, 32'h00000020, 32'h0,        2'b00);
    issue("addi_rt0",  32'h2000FFFF, 32'h0,        1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  2'b00, 1'b1, 32'hFFFFFFFF, 32'h0,        2'b00);
    issue("addi",      32'h20450010, 32'h0,        1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 5'd5,  5'd2,  5'd5,  2'b00, 1'b1, 32'h00000010, 32'h0,        2'b00);
    issue("beq_taken", 32'h10220004, 32'h100,      1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 5'd0,  5'd1,  5'd2,  2'b01, 1'b0, 32'h00000004, 32'h114,      2'b10);
    issue("beq_not",   32'h10220004, 32'h100,      1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  2'b01, 1'b0, 32'h00000004, 32'h0,        2'b10);
    issue("beq_wrap",  32'h10000000, 32'hFFFFFFFC, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  2'b01, 1'b0, 32'h00000000, 32'h0,        2'b10);
    issue("j",         32'h08000040, 32'h10000000, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 32'h00000040, 32'h10000100, 2'b11);
    issue("nop_op",    32'hFC000000, 32'h0,        1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  2'b00, 1'b0, 32'h00000000, 32'h0,        2'b11);
    issue("nop_funct", 32'h00221821, 32'h0,        1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  2'b00, 1'b0, 32'h00001821, 32'h0,        2'b11);

    // Reset while in WB: the write strobe must drop immediately.
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstwb_ready", {31'd0, instr_ready}, 32'd1);
    instr = 32'h00221820;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rstwb_write_before", {31'd0, write}, 32'd1);
    clr_n = 1'b0;
    #1;
    chk("rstwb_write_after", {31'd0, write}, 32'd0);
    chk("rstwb_inc_after", {31'd0, inc}, 32'd0);
    chk("rstwb_state_after", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    chk("rstwb_ready_at_release", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("rstwb_ready_first_cycle", {31'd0, instr_ready}, 32'd1);

    // Overflow on add.
`ifdef OVERFLOW_TRAP_EN
    issue("add_ovf", 32'h00221820, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
    repeat (3) @(negedge clk);
    chk("trap_set", {31'd0, trap}, 32'd1);
    chk("trap_ready", {31'd0, instr_ready}, 32'd0);
    f_overflow = 1'b0;
    instr_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("trap_hold", {29'd0, trap, instr_ready, write | inc | ld}, 32'b100);
    instr_valid = 1'b0;
    do_reset("trap_clear");
`else
    issue("add_ovf", 32'h00221820, 32'h0, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 2'b00, 1'b0, 32'h00001820, 32'h0, 2'b00);
    repeat (5) @(negedge clk);
    chk("ovf_ignored_trap", {31'd0, trap}, 32'd0);
    do_reset("final_reset");
`endif

    repeat (6) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
